memory: RTL and testbench
=========================

MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have a single clock input named clk, 1 bit. All state updates occur on the rising edge of clk.
REQ-002 SHALL have a reset input named rst, 1 bit. Reset is synchronous and active-high.
REQ-003 SHALL have input mib, 1 bit: the serial memory-input bit.
REQ-004 SHALL have input tn_in, 1 bit, active-high: write gate.
REQ-005 SHALL have input tn_clr, 1 bit, active-low: erase gate. Its idle level is 1.
REQ-006 SHALL have input tn_out, 1 bit, active-high: read gate.
REQ-007 SHALL have output mob_tn, 1 bit: the serial memory-output bit.
REQ-008 SHALL have output monitor, 576 bits: a parallel view of the whole store, bit i = storage cell i.
REQ-009 SHALL have no parameters. Capacity is fixed at 576 bits (one long tank).

Function
REQ-010 SHALL model a circulating delay-line tank as a 576-cell bit store plus a position pointer p, range 0..575.
- The cells are static; circulation is modelled by advancing p.
REQ-011 SHALL increment p by 1 on every clock edge when rst=0, with no enable.
- p wraps from 575 to 0.
REQ-012 SHALL define the current bit cur = cell[p].
REQ-013 SHALL, on every non-reset edge, write cell[p] with the following value, in priority order:
- tn_in=1: write mib.
- else tn_clr=0: write 0.
- else: write cur (recirculate, content unchanged).
REQ-014 SHALL give tn_in priority over tn_clr when tn_in=1 and tn_clr=0 on the same edge: mib is written.
REQ-015 SHALL drive mob_tn = tn_out AND cur, combinationally.
- No latency: the bit at position p is visible during the cycle in which p points at it.
REQ-016 SHALL drive mob_tn=0 whenever tn_out=0, independent of the store contents.
REQ-017 SHALL drive monitor combinationally as the direct contents of the 576 cells, in fixed absolute order. monitor does not rotate with p.
REQ-018 SHALL make a written bit visible on monitor one clock edge after the write, and on mob_tn the next time p returns to that cell, 576 cycles later.
REQ-019 SHALL keep all cells not addressed by p unchanged on each edge.
REQ-020 SHALL treat mib as don't-care whenever tn_in=0.
REQ-021 SHALL keep the store holding its data across any number of cycles with tn_in=0 and tn_clr=1.
REQ-022 SHALL keep mob_tn and monitor free of X after reset.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, clear all 576 cells to 0 and set p to 0, regardless of the gate inputs.
REQ-024 SHALL hold all cells at 0 and p at 0 on every edge while rst remains 1.
REQ-025 SHALL, immediately after reset: monitor = all zeros, and mob_tn = 0 for any tn_out value.
REQ-026 SHALL, when rst is asserted mid-operation (during a write or an erase), discard the write or erase in progress and apply the reset values.
REQ-027 SHALL, on the first edge with rst=0, operate on cell 0 and advance p to 1.

Verification
REQ-028 Idle: reset, then 1200 cycles with tn_in=0, tn_clr=1, tn_out=1 -> monitor stays all 0 and mob_tn stays 0.
REQ-029 Write and read-back:
- Stimulus: reset; on the first three edges tn_in=1 with mib=1,0,1; then tn_in=0.
- Response: monitor[2:0]=3'b101.
- Response with tn_out=1: mob_tn=1 during the cycles when p=0 and p=2 (cycles 576 and 578 after reset), and 0 when p=1.
REQ-030 Erase:
- Stimulus: fill the store with tn_in=1, mib=1 for 576 cycles; then drive tn_clr=0 while p=10..13.
- Response: monitor[13:10]=0 and all other bits 1; the erased bits stay 0 on later laps.
REQ-031 Priority: tn_in=1, mib=1, tn_clr=0 at p=5 -> monitor[5]=1.
REQ-032 Read gate: store holds 1s and tn_out=0 -> mob_tn=0 on every cycle; tn_out=1 -> mob_tn=1 on every cycle.
REQ-033 Reset mid-write: rst=1 during a tn_in=1 burst at p=300 -> on the next edge monitor = all 0 and p = 0; normal operation resumes when rst drops.

Source files
------------

// File: rtl/memory.sv
// memory: 576-bit circulating delay-line tank with serial write, erase and read gates
module memory (
    input  logic         clk,
    input  logic         rst,
    input  logic         mib,
    input  logic         tn_in,
    input  logic         tn_clr,
    input  logic         tn_out,
    output logic         mob_tn,
    output logic [575:0] monitor
);
    logic [575:0] cells;
    logic [9:0]   p;
    logic         cur;
    assign cur     = cells[p];
    assign mob_tn  = tn_out & cur;
    assign monitor = cells;
    always_ff @(posedge clk) begin
        if (rst) begin
            cells <= '0;
            p     <= '0;
        end else begin
            cells[p] <= tn_in ? mib : (tn_clr & cur);
            p        <= (p == 10'd575) ? 10'd0 : p + 10'd1;
        end
    end
endmodule

// File: tb/tb_memory.sv
// tb_memory: randomized and directed checks of the delay-line tank against a behavioural model
module tb_memory;
    logic         clk = 1'b0;
    logic         rst, mib, tn_in, tn_clr, tn_out;
    logic         mob_tn;
    logic [575:0] monitor;
    logic [575:0] mdl = '0;
    logic [575:0] exp_v;
    int           mp = 0;
    bit           live = 1'b0;
    int           total = 0;
    int           bad = 0;

    memory dut (
        .clk(clk), .rst(rst), .mib(mib), .tn_in(tn_in), .tn_clr(tn_clr),
        .tn_out(tn_out), .mob_tn(mob_tn), .monitor(monitor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [575:0] got, input logic [575:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    // Reference tank: a bit vector and a position that walks one cell per clock
    always @(posedge clk) begin
        if (rst) begin
            mdl  <= '0;
            mp   <= 0;
            live <= 1'b1;
        end else begin
            if (tn_in) mdl[mp] <= mib;
            else if (!tn_clr) mdl[mp] <= 1'b0;
            mp <= (mp + 1) % 576;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("mob_tn", {575'd0, mob_tn}, {575'd0, tn_out & mdl[mp]});
            chk("monitor", monitor, mdl);
        end
    end

    task automatic step(input logic i, input logic m, input logic c, input logic o);
        tn_in = i; mib = m; tn_clr = c; tn_out = o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic o);
        repeat (n) step(1'b0, 1'($urandom), 1'b1, o);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic fill_ones();
        repeat (576) step(1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        rst = 1'b1; mib = 1'b0; tn_in = 1'b0; tn_clr = 1'b1; tn_out = 1'b1;
        do_reset();
        chk("rst_monitor", monitor, '0);
        chk("rst_mob", {575'd0, mob_tn}, '0);
        chk("rst_model_p", 576'(mp), '0);

        idle(1200, 1'b1);
        chk("idle_monitor", monitor, '0);

        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("wr_monitor", {573'd0, monitor[2:0]}, 576'd5);
        chk("wr_model", {573'd0, mdl[2:0]}, 576'd5);
        idle(573, 1'b1);
        chk("rd_p0", {575'd0, mob_tn}, 576'd1);
        idle(1, 1'b1);
        chk("rd_p1", {575'd0, mob_tn}, 576'd0);
        idle(1, 1'b1);
        chk("rd_p2", {575'd0, mob_tn}, 576'd1);

        do_reset();
        fill_ones();
        chk("fill", monitor, '1);
        idle(10, 1'b1);
        repeat (4) step(1'b0, 1'($urandom), 1'b0, 1'b1);
        idle(562, 1'b1);
        exp_v = '1;
        exp_v[13:10] = 4'b0000;
        chk("erase", monitor, exp_v);
        chk("erase_model", mdl, exp_v);
        idle(576, 1'b1);
        chk("erase_lap", monitor, exp_v);

        do_reset();
        idle(5, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("priority", monitor, 576'd1 << 5);

        do_reset();
        fill_ones();
        repeat (576) begin
            step(1'b0, 1'($urandom), 1'b1, 1'b0);
            chk("gate_off", {575'd0, mob_tn}, '0);
        end
        repeat (576) begin
            step(1'b0, 1'($urandom), 1'b1, 1'b1);
            chk("gate_on", {575'd0, mob_tn}, 576'd1);
        end

        do_reset();
        repeat (300) step(1'b1, 1'($urandom), 1'b1, 1'b1);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("midrst_monitor", monitor, '0);
        chk("midrst_mob", {575'd0, mob_tn}, '0);
        chk("midrst_model_p", 576'(mp), '0);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("resume", monitor, 576'd1);

        repeat (3000) begin
            rst = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 9) < 3, 1'($urandom), $urandom_range(0, 9) >= 2, 1'($urandom));
        end
        rst = 1'b0;
        idle(600, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
